// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock, with valid/ready
// handshakes on both sides; result is held in DONE until accepted downstream.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             d_bit, bn_bit;

  full_subtractor u_fs (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .bin (br_q),
    .d   (d_bit),
    .bout(bn_bit)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = borrow_in;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = bn_bit;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // The MSB result bit is d_bit itself, so overflow is judged on it directly.
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bn_bit;
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized bench for serial_subtractor with a result scoreboard.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           edge_n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   txn    = 0;
  bit   acc;
  bit   seen_valid = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow)
  );

  full_subtractor u_fs_chk (
    .a   (fs_a),
    .b   (fs_b),
    .bin (fs_bin),
    .d   (fs_d),
    .bout(fs_bout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t       e;
    logic [W:0] full;
    full     = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.a      = ma;
    e.b      = mb;
    e.d      = full[W-1:0];
    e.bo     = full[W];
    e.ov     = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
    e.edge_n = 0;
    return e;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst_n) begin
      sb.delete();
      seen_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'(0));
        end else begin
          e = sb[0];
          chk("diff", 32'(diff), 32'(e.d));
          chk("borrow_out", 32'(borrow_out), 32'(e.bo));
          chk("overflow", 32'(overflow), 32'(e.ov));
          chk("in_ready_in_done", 32'(in_ready), 32'(0));
          if (!seen_valid) chk("latency", 32'(cyc - e.edge_n), 32'(W));
          seen_valid = 1'b1;
          if (out_ready) begin
            void'(sb.pop_front());
            seen_valid = 1'b0;
            txn++;
            $display("txn %0d a=%02h b=%02h diff=%02h borrow_out=%0b overflow=%0b",
                     txn, e.a, e.b, diff, borrow_out, overflow);
          end
        end
      end
      if (in_valid && in_ready) begin
        e        = model(a, b, borrow_in);
        e.edge_n = cyc + 1;
        sb.push_back(e);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sbv, input logic sbin);
    int n;
    a         = sa;
    b         = sbv;
    borrow_in = sbin;
    in_valid  = 1'b1;
    n         = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    int n;
    int sent;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    out_ready = 1'b1;

    for (int v = 0; v < 8; v++) begin
      logic [2:0] vec;
      int         r;
      vec    = 3'(v);
      fs_a   = vec[2];
      fs_b   = vec[1];
      fs_bin = vec[0];
      #1;
      r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
      chk("fs_d", 32'(fs_d), 32'(r & 1));
      chk("fs_bout", 32'(fs_bout), 32'(r < 0));
    end

    cycle();
    cycle();
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_borrow_out", 32'(borrow_out), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    rst_n = 1'b1;

    send(8'h05, 8'h03, 1'b0);
    drain();
    chk("in_ready_after_done", 32'(in_ready), 32'(1));

    send(8'h03, 8'h05, 1'b0); drain();
    send(8'h00, 8'h00, 1'b1); drain();
    send(8'h80, 8'h01, 1'b0); drain();
    send(8'h7F, 8'hFF, 1'b0); drain();

    // Backpressure with a competing operand held on the input.
    out_ready = 1'b0;
    send(8'h10, 8'h01, 1'b0);
    a        = 8'h33;
    b        = 8'h11;
    in_valid = 1'b1;
    n        = 0;
    while (!out_valid && n < 50) begin
      cycle();
      n++;
    end
    chk("bp_valid_rise", 32'(out_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_diff_held", 32'(diff), 32'(8'h0F));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_no_accept", 32'(sb.size()), 32'(1));
    end
    out_ready = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 50);
    chk("bp_second_accepted", 32'(acc), 32'(1));
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a shift.
    send(8'hAA, 8'h55, 1'b0);
    cycle(); cycle(); cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_diff", 32'(diff), 32'(0));
    chk("mid_rst_borrow_out", 32'(borrow_out), 32'(0));
    chk("mid_rst_overflow", 32'(overflow), 32'(0));
    for (int i = 0; i < 12; i++) cycle();
    send(8'h01, 8'h01, 1'b0);
    drain();

    // Randomized traffic.
    sent = 0;
    n    = 0;
    a         = 8'($urandom_range(0, 255));
    b         = 8'($urandom_range(0, 255));
    borrow_in = 1'($urandom_range(0, 1));
    while (sent < 200 && n < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
      if (acc) begin
        sent++;
        a         = 8'($urandom_range(0, 255));
        b         = 8'($urandom_range(0, 255));
        borrow_in = 1'($urandom_range(0, 1));
      end
    end
    chk("random_sent", 32'(sent), 32'(200));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes diff = a - b - borrow_in, processing one bit per clock, LSB first. It is built from a single-bit full subtractor and a registered borrow. It is the inverse-direction companion to the team's full-adder arithmetic cells. Operands arrive on a valid/ready input handshake, and results leave on a valid/ready output handshake toward downstream datapath logic.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
in_valid  input  1  operands a, b and borrow_in are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend (unsigned or two's complement)
b  input  WIDTH  subtrahend
borrow_in  input  1  incoming borrow
out_valid  output  1  diff, borrow_out and overflow are valid
out_ready  input  1  downstream accepts the result
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
borrow_out  output  1  1 iff unsigned a < b + borrow_in
overflow  output  1  signed overflow of the two's-complement subtraction

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; in_ready=1; out_valid=0; diff=0; borrow_out=0; overflow=0.
  - Internal shift registers, borrow register and bit counter are cleared.
  - Reset overrides every other event, including mid-SHIFT and DONE; any in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid & in_ready at an edge.
  - On accept: load a_sh<=a, b_sh<=b, br<=borrow_in, cnt<=0; capture a_msb=a[WIDTH-1] and b_msb=b[WIDTH-1]; go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0; in_valid is ignored.
  - Each cycle the full_subtractor computes d = a_sh[0]^b_sh[0]^br and bn = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
  - Each edge: res<={d,res[WIDTH-1:1]}; a_sh and b_sh shift right by 1; br<=bn; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: diff<={d,res[WIDTH-1:1]}, borrow_out<=bn, overflow<=(a_msb!=b_msb)&&(d!=a_msb); go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - diff, borrow_out and overflow are held stable until out_valid & out_ready at an edge, then go to IDLE.
  - out_valid is never withdrawn before the handshake completes.
- Latency: operands accepted at edge k produce out_valid=1 after edge k+WIDTH.
- Minimum spacing between accepts is WIDTH+2 cycles: if out_ready is held high, DONE lasts exactly 1 cycle.
- No input/output overlap: a new accept is impossible while SHIFT or DONE is active. Input is registered only at accept, so a and b may change freely afterwards.
- diff, borrow_out and overflow keep their last values in IDLE; they are only meaningful while out_valid=1.
- cnt has width $clog2(WIDTH); its wrap is never reached because of the DONE transition.

Decomposition:
- Package sub_pkg holds:
  - state_t enum {IDLE, SHIFT, DONE};
  - localparam function cnt_w(WIDTH) = $clog2(WIDTH).
- Natural sub-module: full_subtractor (inputs a, b, bin; outputs d, bout; purely combinational), instantiated once inside serial_subtractor.
- Test plan coverage for full_subtractor: exhaustive 8-vector check in its own small bench, mirroring the full_adder bench.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, borrow_in=0, out_ready=1 -> after exactly 8 edges out_valid=1; diff=0x02, borrow_out=0, overflow=0; in_ready returns to 1 one cycle later.
- a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1, overflow=0. Also a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, overflow=0.
- a=0x80, b=0x01, borrow_in=0 -> diff=0x7F, borrow_out=0, overflow=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- Backpressure: a=0x10, b=0x01, out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and a different operand held throughout -> diff=0x0F held stable, in_ready=0, second operand not accepted. Raise out_ready -> IDLE, then the second operand is accepted.
- Reset mid-SHIFT: start a=0xAA, b=0x55, assert rst_n=0 at cnt=3 for 1 cycle -> state=IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0, overflow=0; no result emerges later. A subsequent a=0x01, b=0x01 gives diff=0x00, borrow_out=0.
- Back-to-back randomized: 200 operand pairs with random in_valid/out_ready -> each result matches the reference model; accept-to-valid latency is exactly WIDTH when out_ready does not stall.
